fetch_stage: RTL and testbench

//  Instruction-fetch stage: owns the program counter and drives iaddr of the

---
 rtl/cpu_pkg.sv | 28 ++
 rtl/fetch_stage_if.sv | 27 ++
 rtl/fetch_stage_pc_reg.sv | 30 +++
 rtl/fetch_stage.sv | 115 +++++++++++
 tb/tb_fetch_stage.sv | 197 +++++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: address/instruction words, fetch FSM states
// and the IF/ID pipeline register payload.
package cpu_pkg;

  localparam int unsigned XLEN = 32;

  typedef logic [XLEN-1:0] addr_t;
  typedef logic [XLEN-1:0] instr_t;

  // addi x0,x0,0
  localparam instr_t NOP_INSTR = 32'h0000_0013;

  // Sequential fetch step in bytes
  localparam addr_t PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } fetch_state_t;

  typedef struct packed {
    addr_t  pc;
    instr_t instr;
    logic   valid;
  } if_id_t;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: imem address/data, decode back-pressure, execute redirect
// and the IF/ID register outputs.
//  master : the fetch stage (drives iaddr and if_id_*)
//  slave  : the surrounding pipeline/imem (drives idata, stall, redirect)
interface fetch_stage_if;
  import cpu_pkg::*;

  addr_t  iaddr;
  instr_t idata;
  logic   stall_i;
  logic   redirect_i;
  addr_t  redirect_pc_i;
  addr_t  if_id_pc;
  instr_t if_id_instr;
  logic   if_id_valid;

  modport master (
    output iaddr, if_id_pc, if_id_instr, if_id_valid,
    input  idata, stall_i, redirect_i, redirect_pc_i
  );

  modport slave (
    input  iaddr, if_id_pc, if_id_instr, if_id_valid,
    output idata, stall_i, redirect_i, redirect_pc_i
  );

endinterface

// File: rtl/fetch_stage_pc_reg.sv
// Program counter flop with load, hold and increment-by-4.
//  clk, reset : clock, async active-high reset (pc <= RESET_PC)
//  load       : take load_pc (has priority over inc)
//  inc        : advance by 4, modulo 2^32
//  load_pc    : redirect target
//  pc         : current program counter
module pc_reg
  import cpu_pkg::*;
#(
  parameter addr_t RESET_PC = 32'h0000_0000
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  load,
  input  logic  inc,
  input  addr_t load_pc,
  output addr_t pc
);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc <= RESET_PC;
    end else if (load) begin
      pc <= load_pc;
    end else if (inc) begin
      pc <= pc + PC_STEP;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, drives the combinational imem and
// latches the returned word into the IF/ID register. Handles decode stall,
// execute redirect with flush, and halts on a misaligned redirect target.
//  clk, reset  : clock, async active-high reset
//  bus         : fetch_stage_if master (iaddr/idata, stall, redirect, IF/ID)
//  misalign_o  : sticky misaligned-redirect flag
//  fetch_cnt_o : saturating count of instructions latched into IF/ID
module fetch_stage
  import cpu_pkg::*;
#(
  parameter addr_t       RESET_PC  = 32'h0000_0000,
  parameter instr_t      NOP_INSTR = cpu_pkg::NOP_INSTR,
  parameter int unsigned CNT_W     = 16
) (
  input  logic               clk,
  input  logic               reset,
  fetch_stage_if.master      bus,
  output logic               misalign_o,
  output logic [CNT_W-1:0]   fetch_cnt_o
);

  fetch_state_t state;
  fetch_state_t state_next;
  if_id_t       if_id;
  addr_t        pc;

  logic target_misaligned;
  logic pc_load;
  logic pc_inc;
  logic capture;
  logic flush;
  logic misalign_set;

  assign target_misaligned = (bus.redirect_pc_i[1:0] != 2'b00);

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: BOOT is a single settling cycle, HALT is terminal
  always_comb begin
    state_next = state;
    case (state)
      BOOT:    state_next = RUN;
      RUN:     if (bus.redirect_i && target_misaligned) state_next = HALT;
      HALT:    state_next = HALT;
      default: state_next = BOOT;
    endcase
  end

  // Control decode: redirect beats stall beats advance, only while running
  always_comb begin
    pc_load      = 1'b0;
    pc_inc       = 1'b0;
    capture      = 1'b0;
    flush        = 1'b0;
    misalign_set = 1'b0;
    if (state == RUN) begin
      if (bus.redirect_i) begin
        if (target_misaligned) begin
          misalign_set = 1'b1;
        end else begin
          pc_load = 1'b1;
          flush   = 1'b1;
        end
      end else if (!bus.stall_i) begin
        pc_inc  = 1'b1;
        capture = 1'b1;
      end
    end
  end

  pc_reg #(
    .RESET_PC (RESET_PC)
  ) u_pc_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (pc_load),
    .inc     (pc_inc),
    .load_pc (bus.redirect_pc_i),
    .pc      (pc)
  );

  // IF/ID register, sticky misalign flag and saturating fetch counter
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      if_id       <= '{pc: '0, instr: NOP_INSTR, valid: 1'b0};
      misalign_o  <= 1'b0;
      fetch_cnt_o <= '0;
    end else if (flush) begin
      if_id.valid <= 1'b0;
      if_id.instr <= NOP_INSTR;
    end else if (misalign_set) begin
      if_id.valid <= 1'b0;
      misalign_o  <= 1'b1;
    end else if (capture) begin
      if_id <= '{pc: pc, instr: bus.idata, valid: 1'b1};
      if (fetch_cnt_o != {CNT_W{1'b1}}) begin
        fetch_cnt_o <= fetch_cnt_o + CNT_W'(1);
      end
    end
  end

  // imem is combinational, so the address is simply the live PC
  assign bus.iaddr       = pc;
  assign bus.if_id_pc    = if_id.pc;
  assign bus.if_id_instr = if_id.instr;
  assign bus.if_id_valid = if_id.valid;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/redirect traffic compared against a cycle-level reference model.
module tb_fetch_stage;
  import cpu_pkg::*;

  localparam int unsigned CNT_W   = 16;
  localparam int          CNT_MAX = (1 << CNT_W) - 1;
  localparam longint      PC_MOD  = 64'h1_0000_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic             misalign;
  logic [CNT_W-1:0] fetch_cnt;

  fetch_stage_if bus();

  fetch_stage #(
    .RESET_PC  (32'h0000_0000),
    .NOP_INSTR (32'h0000_0013),
    .CNT_W     (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus.master),
    .misalign_o  (misalign),
    .fetch_cnt_o (fetch_cnt)
  );

  always #5 clk = ~clk;

  // Instruction memory contents: a fixed scramble of the byte address
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0003;
  endfunction

  always_comb bus.idata = mem_word(bus.iaddr);

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model, stated in terms of architectural effects per edge
  longint      m_pc;
  int          m_cnt;
  logic [31:0] m_ifpc;
  logic [31:0] m_instr;
  bit          m_valid;
  bit          m_mis;
  bit          m_halted;
  bit          m_boot;

  task automatic model_reset();
    m_pc = 0; m_cnt = 0; m_ifpc = 32'h0; m_instr = 32'h13;
    m_valid = 0; m_mis = 0; m_halted = 0; m_boot = 1;
  endtask

  task automatic model_edge(input bit st, input bit rd, input logic [31:0] rp);
    if (m_boot) begin
      m_boot = 0;
    end else if (!m_halted) begin
      if (rd && rp[1:0] == 2'b00) begin
        m_pc = longint'(rp); m_valid = 0; m_instr = 32'h13;
      end else if (rd) begin
        m_mis = 1; m_valid = 0; m_halted = 1;
      end else if (!st) begin
        m_instr = mem_word(32'(m_pc));
        m_ifpc  = 32'(m_pc);
        m_valid = 1;
        m_pc    = (m_pc + 4) % PC_MOD;
        m_cnt   = (m_cnt < CNT_MAX) ? m_cnt + 1 : CNT_MAX;
      end
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, "_iaddr"}, bus.iaddr, 32'(m_pc));
    check({tag, "_ifpc"},  bus.if_id_pc, m_ifpc);
    check({tag, "_instr"}, bus.if_id_instr, m_instr);
    check({tag, "_valid"}, 32'(bus.if_id_valid), 32'(m_valid));
    check({tag, "_mis"},   32'(misalign), 32'(m_mis));
    check({tag, "_cnt"},   32'(fetch_cnt), 32'(m_cnt));
  endtask

  // One clock: drive inputs, confirm iaddr before the edge, check after it
  task automatic step(input bit st, input bit rd, input logic [31:0] rp, input string tag);
    bus.stall_i = st;
    bus.redirect_i = rd;
    bus.redirect_pc_i = rp;
    check({tag, "_pre_iaddr"}, bus.iaddr, 32'(m_pc));
    @(posedge clk);
    model_edge(st, rd, rp);
    #1;
    check_all(tag);
  endtask

  initial begin
    reset = 1'b1;
    bus.stall_i = 1'b0;
    bus.redirect_i = 1'b0;
    bus.redirect_pc_i = 32'h0;
    model_reset();
    #12;
    check_all("reset");
    @(negedge clk);
    reset = 1'b0;

    // BOOT cycle then three sequential fetches
    step(0, 0, 32'h0, "boot");
    check("boot_iaddr", bus.iaddr, 32'h0);
    step(0, 0, 32'h0, "adv0");
    check("adv0_pc", bus.if_id_pc, 32'h0);
    check("adv0_cnt", 32'(fetch_cnt), 32'd1);
    step(0, 0, 32'h0, "adv1");
    check("adv1_instr", bus.if_id_instr, mem_word(32'h4));

    // Stall three cycles holding (4,B)
    for (int i = 0; i < 3; i++) step(1, 0, 32'h0, "stall");
    check("stall_iaddr", bus.iaddr, 32'h8);
    check("stall_pc", bus.if_id_pc, 32'h4);
    check("stall_cnt", 32'(fetch_cnt), 32'd2);
    step(0, 0, 32'h0, "unstall");
    check("unstall_pc", bus.if_id_pc, 32'h8);

    // Redirect coincident with stall flushes and loads target
    step(1, 1, 32'h40, "redir");
    check("redir_instr", bus.if_id_instr, 32'h13);
    check("redir_valid", 32'(bus.if_id_valid), 32'd0);
    check("redir_iaddr", bus.iaddr, 32'h40);
    step(0, 0, 32'h0, "redir_tgt");
    check("redir_tgt_pc", bus.if_id_pc, 32'h40);
    check("redir_tgt_instr", bus.if_id_instr, mem_word(32'h40));

    // PC wrap at the top of the address space
    step(0, 1, 32'hFFFF_FFFC, "top");
    step(0, 0, 32'h0, "wrap");
    check("wrap_iaddr", bus.iaddr, 32'h0);
    check("wrap_ifpc", bus.if_id_pc, 32'hFFFF_FFFC);

    // Randomized stall/redirect traffic, aligned targets only
    for (int i = 0; i < 400; i++) begin
      bit          st;
      bit          rd;
      logic [31:0] rp;
      st = ($urandom_range(0, 99) < 30);
      rd = ($urandom_range(0, 99) < 10);
      rp = $urandom & 32'hFFFF_FFFC;
      step(st, rd, rp, "rand");
    end

    // Asynchronous reset mid-cycle: outputs clear before the next edge
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 32'h0, "reboot");
    check("reboot_valid", 32'(bus.if_id_valid), 32'd0);
    step(0, 0, 32'h0, "reboot_adv");

    // Counter saturation
    for (int i = 0; i < CNT_MAX + 4; i++) step(0, 0, 32'h0, "sat");
    check("sat_cnt", 32'(fetch_cnt), 32'h0000_FFFF);

    // Misaligned redirect halts the stage; later traffic is ignored
    step(0, 1, 32'h42, "mis");
    check("mis_flag", 32'(misalign), 32'd1);
    check("mis_valid", 32'(bus.if_id_valid), 32'd0);
    for (int i = 0; i < 8; i++) begin
      step(bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           $urandom & 32'hFFFF_FFFC, "halt");
    end
    check("halt_flag", 32'(misalign), 32'd1);

    // Reset clears the halt
    #2 reset = 1'b1;
    #1;
    model_reset();
    check_all("halt_rst");
    check("halt_rst_mis", 32'(misalign), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    step(0, 0, 32'h0, "boot2");
    step(0, 0, 32'h0, "adv2");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
